// File: rtl/npc_predict.sv
// npc_predict: fetch PC register plus a direct-mapped BTB of 2-bit counters.
// Predicts the next PC every cycle. Resolved outcomes from EX train the table
// and raise a redirect when the prediction carried down the pipe was wrong.

// One BTB entry: valid, tag, target and a 2-bit saturating counter.
module npc_btb_entry #(
  parameter int WIDTH = 32,
  parameter int TAGW  = 26
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wr_en,
  input  logic             res_taken,
  input  logic [TAGW-1:0]  res_tag,
  input  logic [WIDTH-1:0] res_target,
  output logic             valid,
  output logic [TAGW-1:0]  tag,
  output logic [WIDTH-1:0] target,
  output logic [1:0]       ctr
);
  // Train on a hit, allocate as weakly-taken on a taken miss, ignore a not-taken miss
  always_ff @(posedge clk) begin
    if (rst) begin
      valid  <= 1'b0;
      tag    <= '0;
      target <= '0;
      ctr    <= 2'd1;
    end else if (wr_en) begin
      if (valid && tag == res_tag) begin
        if (res_taken) begin
          if (ctr != 2'd3) ctr <= ctr + 2'd1;
          target <= res_target;
        end else if (ctr != 2'd0) begin
          ctr <= ctr - 2'd1;
        end
      end else if (res_taken) begin
        valid  <= 1'b1;
        tag    <= res_tag;
        target <= res_target;
        ctr    <= 2'd2;
      end
    end
  end
endmodule

module npc_predict #(
  parameter int               WIDTH    = 32,
  parameter int               ENTRIES  = 16,
  parameter logic [WIDTH-1:0] RESET_PC = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             stall_in,
  output logic [WIDTH-1:0] pc_out,
  output logic             pred_taken_out,
  output logic [WIDTH-1:0] pred_target_out,
  input  logic             res_valid_in,
  input  logic [WIDTH-1:0] res_pc_in,
  input  logic             res_taken_in,
  input  logic [WIDTH-1:0] res_target_in,
  input  logic             res_pred_taken_in,
  input  logic [WIDTH-1:0] res_pred_target_in,
  output logic             redirect_out,
  output logic [WIDTH-1:0] redirect_pc_out,
  output logic [31:0]      branch_cnt_out,
  output logic [31:0]      miss_cnt_out
);
  localparam int IDX  = $clog2(ENTRIES);
  localparam int TAGW = WIDTH - IDX - 2;

  logic [ENTRIES-1:0]            e_valid;
  logic [ENTRIES-1:0][TAGW-1:0]  e_tag;
  logic [ENTRIES-1:0][WIDTH-1:0] e_target;
  logic [ENTRIES-1:0][1:0]       e_ctr;

  logic [IDX-1:0]  look_idx, res_idx;
  logic [TAGW-1:0] look_tag, res_tag;
  logic            upd_en;

  assign look_idx = pc_out[IDX+1:2];
  assign look_tag = pc_out[WIDTH-1:IDX+2];
  assign res_idx  = res_pc_in[IDX+1:2];
  assign res_tag  = res_pc_in[WIDTH-1:IDX+2];
  // A resolve in the reset cycle is dropped entirely.
  assign upd_en   = res_valid_in && !rst;

  for (genvar i = 0; i < ENTRIES; i++) begin : g_btb
    npc_btb_entry #(.WIDTH(WIDTH), .TAGW(TAGW)) u_ent (
      .clk        (clk),
      .rst        (rst),
      .wr_en      (upd_en && res_idx == IDX'(i)),
      .res_taken  (res_taken_in),
      .res_tag    (res_tag),
      .res_target (res_target_in),
      .valid      (e_valid[i]),
      .tag        (e_tag[i]),
      .target     (e_target[i]),
      .ctr        (e_ctr[i])
    );
  end

  // Zero-cycle lookup for the current fetch PC; sees pre-update table contents
  always_comb begin
    pred_taken_out  = 1'b0;
    pred_target_out = pc_out + WIDTH'(4);
    if (e_valid[look_idx] && e_tag[look_idx] == look_tag && e_ctr[look_idx][1]) begin
      pred_taken_out  = 1'b1;
      pred_target_out = e_target[look_idx];
    end
  end

  // Mispredict detection on the resolved instruction; target only matters if both said taken
  always_comb begin
    redirect_out    = 1'b0;
    redirect_pc_out = '0;
    if (res_valid_in &&
        (res_taken_in != res_pred_taken_in ||
         (res_taken_in && res_pred_taken_in && res_target_in != res_pred_target_in))) begin
      redirect_out    = 1'b1;
      redirect_pc_out = res_taken_in ? res_target_in : res_pc_in + WIDTH'(4);
    end
  end

  // Fetch PC: reset, then redirect (overrides stall), then stall, then prediction
  always_ff @(posedge clk) begin
    if (rst)               pc_out <= RESET_PC;
    else if (redirect_out) pc_out <= redirect_pc_out;
    else if (!stall_in)    pc_out <= pred_target_out;
  end

  // Saturating resolve / mispredict counters
  always_ff @(posedge clk) begin
    if (rst) begin
      branch_cnt_out <= '0;
      miss_cnt_out   <= '0;
    end else begin
      if (res_valid_in && branch_cnt_out != 32'hFFFF_FFFF) branch_cnt_out <= branch_cnt_out + 32'd1;
      if (redirect_out && miss_cnt_out != 32'hFFFF_FFFF)   miss_cnt_out   <= miss_cnt_out + 32'd1;
    end
  end
endmodule

// File: tb/tb_npc_predict.sv
// Bench for npc_predict: directed scenarios plus a randomized run against a
// table model kept as plain arrays indexed by (pc/4)%16, tagged by pc/64.
module tb_npc_predict;
  logic        clk = 1'b0;
  logic        rst, stall_in;
  logic [31:0] pc_out, pred_target_out, res_pc_in, res_target_in, res_pred_target_in;
  logic [31:0] redirect_pc_out, branch_cnt_out, miss_cnt_out;
  logic        pred_taken_out, res_valid_in, res_taken_in, res_pred_taken_in, redirect_out;

  int checks = 0;
  int failures = 0;

  npc_predict #(.WIDTH(32), .ENTRIES(16), .RESET_PC(32'h0)) dut (
    .clk(clk), .rst(rst), .stall_in(stall_in),
    .pc_out(pc_out), .pred_taken_out(pred_taken_out), .pred_target_out(pred_target_out),
    .res_valid_in(res_valid_in), .res_pc_in(res_pc_in), .res_taken_in(res_taken_in),
    .res_target_in(res_target_in), .res_pred_taken_in(res_pred_taken_in),
    .res_pred_target_in(res_pred_target_in), .redirect_out(redirect_out),
    .redirect_pc_out(redirect_pc_out), .branch_cnt_out(branch_cnt_out),
    .miss_cnt_out(miss_cnt_out)
  );

  always #5 clk = ~clk;

  // Reference model state
  logic        m_valid [16];
  logic [31:0] m_tag   [16];
  logic [31:0] m_tgt   [16];
  int          m_ctr   [16];
  logic [31:0] m_pc, m_bcnt, m_mcnt;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_res();
    res_valid_in = 0; res_pc_in = 0; res_taken_in = 0; res_target_in = 0;
    res_pred_taken_in = 0; res_pred_target_in = 0;
  endtask

  task automatic drive_res(input logic [31:0] p, input logic t, input logic [31:0] tg,
                           input logic pt, input logic [31:0] ptg);
    res_valid_in = 1; res_pc_in = p; res_taken_in = t; res_target_in = tg;
    res_pred_taken_in = pt; res_pred_target_in = ptg;
    #1;
  endtask

  task automatic do_reset();
    clear_res();
    stall_in = 0;
    rst = 1;
    tick();
    rst = 0;
    #1;
  endtask

  // Steer fetch to address a with a not-taken resolve at a-4 that was predicted
  // taken (no table change on a miss); leaves the PC stalled there.
  task automatic force_pc(input logic [31:0] a);
    stall_in = 1;
    drive_res(a - 32'd4, 1'b0, 32'h0, 1'b1, 32'h0);
    tick();
    clear_res();
    #1;
  endtask

  function automatic void m_lookup(input logic [31:0] pc, output logic t, output logic [31:0] tg);
    int i;
    i = int'((pc >> 2) % 16);
    if (m_valid[i] && m_tag[i] == (pc >> 6) && m_ctr[i] >= 2) begin
      t = 1'b1; tg = m_tgt[i];
    end else begin
      t = 1'b0; tg = pc + 32'd4;
    end
  endfunction

  function automatic void m_reset();
    for (int i = 0; i < 16; i++) begin
      m_valid[i] = 0; m_tag[i] = 0; m_tgt[i] = 0; m_ctr[i] = 1;
    end
    m_pc = 0; m_bcnt = 0; m_mcnt = 0;
  endfunction

  task automatic test_reset();
    do_reset();
    checks++; if (pc_out !== 32'h0) begin failures++; $display("FAIL reset_pc got=%h exp=0", pc_out); end
    checks++; if (pred_taken_out !== 1'b0) begin failures++; $display("FAIL reset_pred_taken got=%b exp=0", pred_taken_out); end
    checks++; if (pred_target_out !== 32'h4) begin failures++; $display("FAIL reset_pred_target got=%h exp=4", pred_target_out); end
    checks++; if (branch_cnt_out !== 0 || miss_cnt_out !== 0) begin failures++; $display("FAIL reset_counts got=%0d/%0d exp=0/0", branch_cnt_out, miss_cnt_out); end
    checks++; if (redirect_out !== 1'b0 || redirect_pc_out !== 32'h0) begin failures++; $display("FAIL reset_redirect got=%b/%h exp=0/0", redirect_out, redirect_pc_out); end
    for (int k = 1; k <= 3; k++) begin
      tick();
      checks++; if (pc_out !== 32'(4 * k)) begin failures++; $display("FAIL free_run_pc got=%h exp=%h", pc_out, 32'(4 * k)); end
    end
  endtask

  task automatic test_cold_taken();
    do_reset();
    drive_res(32'h10, 1'b1, 32'h40, 1'b0, 32'h14);
    checks++; if (redirect_out !== 1'b1 || redirect_pc_out !== 32'h40) begin failures++; $display("FAIL cold_redirect got=%b/%h exp=1/40", redirect_out, redirect_pc_out); end
    tick(); clear_res(); #1;
    checks++; if (pc_out !== 32'h40) begin failures++; $display("FAIL cold_pc got=%h exp=40", pc_out); end
    checks++; if (branch_cnt_out !== 1 || miss_cnt_out !== 1) begin failures++; $display("FAIL cold_counts got=%0d/%0d exp=1/1", branch_cnt_out, miss_cnt_out); end
    force_pc(32'h10);
    checks++; if (pred_taken_out !== 1'b1 || pred_target_out !== 32'h40) begin failures++; $display("FAIL cold_predict got=%b/%h exp=1/40", pred_taken_out, pred_target_out); end
  endtask

  task automatic test_saturation();
    do_reset();
    drive_res(32'h10, 1'b1, 32'h40, 1'b0, 32'h14); tick();
    drive_res(32'h10, 1'b1, 32'h40, 1'b1, 32'h40);
    checks++; if (redirect_out !== 1'b0) begin failures++; $display("FAIL sat_correct_redirect got=%b exp=0", redirect_out); end
    tick();
    drive_res(32'h10, 1'b1, 32'h40, 1'b1, 32'h40); tick();
    clear_res();
    force_pc(32'h10);
    checks++; if (pred_taken_out !== 1'b1) begin failures++; $display("FAIL sat_ctr3_pred got=%b exp=1", pred_taken_out); end
    drive_res(32'h10, 1'b0, 32'h0, 1'b1, 32'h40);
    checks++; if (redirect_out !== 1'b1 || redirect_pc_out !== 32'h14) begin failures++; $display("FAIL sat_nt_redirect got=%b/%h exp=1/14", redirect_out, redirect_pc_out); end
    tick(); clear_res(); #1;
    checks++; if (pc_out !== 32'h14) begin failures++; $display("FAIL sat_nt_pc got=%h exp=14", pc_out); end
    force_pc(32'h10);
    checks++; if (pred_taken_out !== 1'b1 || pred_target_out !== 32'h40) begin failures++; $display("FAIL sat_ctr2_pred got=%b/%h exp=1/40", pred_taken_out, pred_target_out); end
    drive_res(32'h10, 1'b0, 32'h0, 1'b1, 32'h40); tick(); clear_res();
    force_pc(32'h10);
    checks++; if (pred_taken_out !== 1'b0 || pred_target_out !== 32'h14) begin failures++; $display("FAIL sat_ctr1_pred got=%b/%h exp=0/14", pred_taken_out, pred_target_out); end
  endtask

  task automatic test_jr();
    do_reset();
    drive_res(32'h20, 1'b1, 32'h100, 1'b0, 32'h24); tick();
    drive_res(32'h20, 1'b1, 32'h200, 1'b1, 32'h100);
    checks++; if (redirect_out !== 1'b1 || redirect_pc_out !== 32'h200) begin failures++; $display("FAIL jr_redirect got=%b/%h exp=1/200", redirect_out, redirect_pc_out); end
    tick(); clear_res(); #1;
    checks++; if (pc_out !== 32'h200) begin failures++; $display("FAIL jr_pc got=%h exp=200", pc_out); end
    force_pc(32'h20);
    checks++; if (pred_taken_out !== 1'b1 || pred_target_out !== 32'h200) begin failures++; $display("FAIL jr_entry got=%b/%h exp=1/200", pred_taken_out, pred_target_out); end
  endtask

  task automatic test_stall_redirect();
    do_reset();
    stall_in = 1;
    for (int k = 0; k < 3; k++) begin
      tick();
      checks++; if (pc_out !== 32'h0) begin failures++; $display("FAIL stall_hold got=%h exp=0", pc_out); end
    end
    drive_res(32'h80, 1'b1, 32'h300, 1'b0, 32'h84);
    tick(); clear_res(); #1;
    checks++; if (pc_out !== 32'h300) begin failures++; $display("FAIL stall_redirect_pc got=%h exp=300", pc_out); end
  endtask

  task automatic test_alias();
    do_reset();
    drive_res(32'h10, 1'b1, 32'h40, 1'b0, 32'h14); tick(); clear_res();
    force_pc(32'h10);
    drive_res(32'h50, 1'b1, 32'h90, 1'b0, 32'h54);
    checks++; if (pred_taken_out !== 1'b1 || pred_target_out !== 32'h40) begin failures++; $display("FAIL alias_same_cycle got=%b/%h exp=1/40", pred_taken_out, pred_target_out); end
    tick(); clear_res();
    force_pc(32'h10);
    checks++; if (pred_taken_out !== 1'b0 || pred_target_out !== 32'h14) begin failures++; $display("FAIL alias_evicted got=%b/%h exp=0/14", pred_taken_out, pred_target_out); end
    force_pc(32'h50);
    checks++; if (pred_taken_out !== 1'b1 || pred_target_out !== 32'h90) begin failures++; $display("FAIL alias_new got=%b/%h exp=1/90", pred_taken_out, pred_target_out); end
  endtask

  task automatic test_wrap();
    do_reset();
    force_pc(32'hFFFF_FFFC);
    checks++; if (pc_out !== 32'hFFFF_FFFC || pred_target_out !== 32'h0) begin failures++; $display("FAIL wrap got=%h/%h exp=fffffffc/0", pc_out, pred_target_out); end
  endtask

  task automatic test_random();
    logic        t, pt, et, mis;
    logic [31:0] p, tg, ptg, etg, erpc;
    int          i;
    do_reset();
    m_reset();
    for (int n = 0; n < 400; n++) begin
      rst      = ($urandom_range(0, 49) == 0);
      stall_in = ($urandom_range(0, 3) == 0);
      p  = 32'($urandom_range(0, 31)) << 2;
      t  = 1'($urandom_range(0, 1));
      tg = 32'($urandom_range(0, 63)) << 2;
      m_lookup(p, pt, ptg);
      if ($urandom_range(0, 3) == 0) begin pt = ~pt; ptg = 32'($urandom_range(0, 63)) << 2; end
      if ($urandom_range(0, 1) == 1) drive_res(p, t, tg, pt, ptg);
      else begin clear_res(); #1; end
      m_lookup(m_pc, et, etg);
      mis  = res_valid_in && (t != pt || (t && pt && tg != ptg));
      erpc = mis ? (t ? tg : p + 32'd4) : 32'h0;
      checks++; if (pc_out !== m_pc) begin failures++; $display("FAIL rnd_pc cyc=%0d got=%h exp=%h", n, pc_out, m_pc); end
      checks++; if (pred_taken_out !== et || pred_target_out !== etg) begin failures++; $display("FAIL rnd_pred cyc=%0d got=%b/%h exp=%b/%h", n, pred_taken_out, pred_target_out, et, etg); end
      checks++; if (redirect_out !== mis || redirect_pc_out !== erpc) begin failures++; $display("FAIL rnd_redirect cyc=%0d got=%b/%h exp=%b/%h", n, redirect_out, redirect_pc_out, mis, erpc); end
      checks++; if (branch_cnt_out !== m_bcnt || miss_cnt_out !== m_mcnt) begin failures++; $display("FAIL rnd_counts cyc=%0d got=%0d/%0d exp=%0d/%0d", n, branch_cnt_out, miss_cnt_out, m_bcnt, m_mcnt); end
      if (rst) m_reset();
      else begin
        if (res_valid_in) begin
          i = int'((p >> 2) % 16);
          if (m_bcnt != 32'hFFFF_FFFF) m_bcnt++;
          if (m_valid[i] && m_tag[i] == (p >> 6)) begin
            if (t) begin m_ctr[i] = (m_ctr[i] < 3) ? m_ctr[i] + 1 : 3; m_tgt[i] = tg; end
            else m_ctr[i] = (m_ctr[i] > 0) ? m_ctr[i] - 1 : 0;
          end else if (t) begin
            m_valid[i] = 1; m_tag[i] = p >> 6; m_tgt[i] = tg; m_ctr[i] = 2;
          end
        end
        if (mis && m_mcnt != 32'hFFFF_FFFF) m_mcnt++;
        m_pc = mis ? erpc : (stall_in ? m_pc : etg);
      end
      tick();
    end
    rst = 0;
    clear_res();
  endtask

  initial begin
    rst = 1; stall_in = 0;
    clear_res();
    test_reset();
    test_cold_taken();
    test_saturation();
    test_jr();
    test_stall_redirect();
    test_alias();
    test_wrap();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
